// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter block: default sizes and the
// encodings of the direction and boundary-mode control inputs.
package counter_pkg;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_PRESCALE_W = 8;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

endpackage

// File: rtl/tick_gen.sv
// Clock-enable prescaler: emits a one-cycle tick every prescale+1 enabled
// cycles. A restart forces the phase back to zero without ticking.
module tick_gen
  import counter_pkg::*;
#(
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  restart,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_cnt_q;
  logic [PRESCALE_W-1:0] pre_cnt_d;
  logic                  tick_d;

  // An oversized pre_cnt simply keeps counting and wraps before matching again.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    tick_d    = 1'b0;
    if (restart) begin
      pre_cnt_d = '0;
    end else if (en) begin
      if (pre_cnt_q == prescale) begin
        pre_cnt_d = '0;
        tick_d    = 1'b1;
      end else begin
        pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

  assign tick = tick_d;

endmodule

// File: rtl/mod_counter.sv
// Programmable modulo up/down counter with wrap/saturate boundaries, parallel
// load, prescaled stepping, compare match, terminal-count pulse and sticky flag.
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic                  sat,
  input  logic [WIDTH-1:0]      modulo,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      cmp_val,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  cmp_match,
  output logic                  ovf_sticky
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             cmp_q;
  logic             cmp_d;
  logic             tick;
  logic             at_bound;
  dir_e             dir_s;
  mode_e            mode_s;

  assign dir_s  = dir_e'(dir);
  assign mode_s = mode_e'(sat);

  tick_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .restart  (clr | load),
    .prescale (prescale),
    .tick     (tick)
  );

  // Boundary is decided before any arithmetic, so +1/-1 never leaves WIDTH bits.
  // An up count above modulo counts as at the boundary and collapses on its step.
  always_comb begin
    at_bound = 1'b0;
    if (dir_s == DIR_UP) begin
      at_bound = (count_q >= modulo);
    end else begin
      at_bound = (count_q == '0);
    end
  end

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_val;
    end else if (tick) begin
      if (at_bound) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (dir_s == DIR_UP) begin
          count_d = (mode_s == MODE_SAT) ? modulo : '0;
        end else begin
          count_d = (mode_s == MODE_SAT) ? '0 : modulo;
        end
      end else if (dir_s == DIR_UP) begin
        count_d = count_q + WIDTH'(1);
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  // Compare is taken from the next count so the flag lines up with count itself.
  assign cmp_d = (count_d == cmp_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cmp_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      cmp_q   <= cmp_d;
    end
  end

  assign count      = count_q;
  assign tc         = tc_q;
  assign cmp_match  = cmp_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: hand-computed count/tc/flag sequences for
// wrap, saturate, prescale, priority, out-of-range load and async reset.
module tb_mod_counter;

  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 8;

  logic                  clk;
  logic                  rst_n;
  logic                  en;
  logic                  clr;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic                  dir;
  logic                  sat;
  logic [WIDTH-1:0]      modulo;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      cmp_val;
  logic [WIDTH-1:0]      count;
  logic                  tc;
  logic                  cmp_match;
  logic                  ovf_sticky;

  int checkCount;
  int errorCount;

  mod_counter #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .dir        (dir),
    .sat        (sat),
    .modulo     (modulo),
    .prescale   (prescale),
    .cmp_val    (cmp_val),
    .count      (count),
    .tc         (tc),
    .cmp_match  (cmp_match),
    .ovf_sticky (ovf_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One clock edge, then settle just past it so outputs are sampled off-edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input int expCount, input int expTc,
                            input int expOvf);
    checkOutput({tag, " count"}, 32'(count), 32'(expCount));
    checkOutput({tag, " tc"}, 32'(tc), 32'(expTc));
    checkOutput({tag, " ovf"}, 32'(ovf_sticky), 32'(expOvf));
  endtask

  initial begin
    int wrapCount[8];
    int satCount[5];
    int satTc[5];
    checkCount = 0;
    errorCount = 0;
    wrapCount  = '{1, 2, 3, 4, 5, 0, 1, 2};
    satCount   = '{1, 0, 0, 0, 0};
    satTc      = '{0, 0, 1, 1, 1};

    rst_n    = 1'b0;
    en       = 1'b0;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = '0;
    dir      = 1'b1;
    sat      = 1'b0;
    modulo   = 8'd5;
    prescale = '0;
    cmp_val  = 8'd3;
    applyStimulus();
    applyStimulus();
    checkState("reset", 0, 0, 0);
    checkOutput("reset cmp", 32'(cmp_match), 32'd0);
    rst_n = 1'b1;

    $display("[TB] wrap up, modulo 5");
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      checkOutput($sformatf("wrap%0d count", i), 32'(count), 32'(wrapCount[i]));
      checkOutput($sformatf("wrap%0d tc", i), 32'(tc), (wrapCount[i] == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("wrap%0d cmp", i), 32'(cmp_match),
                  (wrapCount[i] == 3) ? 32'd1 : 32'd0);
    end
    checkOutput("wrap ovf", 32'(ovf_sticky), 32'd1);

    $display("[TB] saturate down");
    en       = 1'b0;
    load     = 1'b1;
    load_val = 8'd2;
    applyStimulus();
    checkState("satload", 2, 0, 1);
    load = 1'b0;
    dir  = 1'b0;
    sat  = 1'b1;
    en   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput($sformatf("sat%0d count", i), 32'(count), 32'(satCount[i]));
      checkOutput($sformatf("sat%0d tc", i), 32'(tc), 32'(satTc[i]));
    end

    $display("[TB] prescale 3");
    clr = 1'b1;
    applyStimulus();
    checkState("clr", 0, 0, 0);
    clr      = 1'b0;
    dir      = 1'b1;
    sat      = 1'b0;
    modulo   = 8'd255;
    prescale = 8'd3;
    for (int i = 1; i <= 12; i++) begin
      applyStimulus();
      checkOutput($sformatf("pre%0d count", i), 32'(count), 32'(i / 4));
    end
    applyStimulus();
    applyStimulus();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("freeze%0d count", i), 32'(count), 32'd3);
    end
    en = 1'b1;
    applyStimulus();
    checkOutput("resume1 count", 32'(count), 32'd3);
    applyStimulus();
    checkOutput("resume2 count", 32'(count), 32'd4);

    $display("[TB] clr/load priority");
    prescale = '0;
    en       = 1'b0;
    clr      = 1'b1;
    load     = 1'b1;
    load_val = 8'd9;
    cmp_val  = 8'd9;
    applyStimulus();
    checkState("prio", 0, 0, 0);
    checkOutput("prio cmp", 32'(cmp_match), 32'd0);
    clr = 1'b0;
    applyStimulus();
    checkOutput("load9 count", 32'(count), 32'd9);
    checkOutput("load9 cmp", 32'(cmp_match), 32'd1);
    load    = 1'b0;
    cmp_val = 8'd8;
    checkOutput("cmpchg before", 32'(cmp_match), 32'd1);
    applyStimulus();
    checkOutput("cmpchg after", 32'(cmp_match), 32'd0);

    $display("[TB] out-of-range load, modulo 4");
    modulo   = 8'd4;
    load     = 1'b1;
    load_val = 8'd7;
    applyStimulus();
    checkState("oor load", 7, 0, 0);
    load = 1'b0;
    dir  = 1'b1;
    sat  = 1'b0;
    en   = 1'b1;
    applyStimulus();
    checkState("oor wrap", 0, 1, 1);
    en   = 1'b0;
    load = 1'b1;
    applyStimulus();
    load = 1'b0;
    sat  = 1'b1;
    en   = 1'b1;
    applyStimulus();
    checkState("oor sat", 4, 1, 1);
    en   = 1'b0;
    load = 1'b1;
    applyStimulus();
    load = 1'b0;
    dir  = 1'b0;
    en   = 1'b1;
    applyStimulus();
    checkState("oor down", 6, 0, 1);

    $display("[TB] modulo 0");
    modulo = '0;
    dir    = 1'b1;
    sat    = 1'b0;
    clr    = 1'b1;
    applyStimulus();
    clr = 1'b0;
    applyStimulus();
    checkState("mod0 up", 0, 1, 1);
    dir = 1'b0;
    applyStimulus();
    checkState("mod0 down", 0, 1, 1);

    $display("[TB] async reset mid-count");
    modulo = 8'd10;
    dir    = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("run%0d count", i), 32'(count), 32'(i));
    end
    checkOutput("run ovf", 32'(ovf_sticky), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkState("async rst", 0, 0, 0);
    #1;
    rst_n = 1'b1;
    applyStimulus();
    checkState("post rst1", 1, 0, 0);
    applyStimulus();
    checkState("post rst2", 2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
